// File: rtl/ext_mem_pkg.sv
// Shared definitions for the external-memory responders: FSM states,
// operation type, default SRAM timing and the SRAM window base address.
package ext_mem_pkg;

  typedef enum logic [2:0] {
    IDLE,
    R_ACC,
    W_SETUP,
    W_PULSE,
    W_HOLD,
    DONE
  } state_t;

  typedef enum logic {
    OP_READ,
    OP_WRITE
  } op_t;

  // Default wait states for a 10ns async SRAM on a 50MHz system clock
  localparam int SRAM_RD_CYCLES = 2;
  localparam int SRAM_WE_CYCLES = 2;

  // Byte base address of the 512KB SRAM window on the CPU bus
  localparam logic [23:0] SRAM_BASE = 24'h400000;

endpackage

// File: rtl/ext_sram_ctrl.sv
// Responder for the SRAM window of the CPU external-memory bus. Latches a
// read or write request, sequences the async SRAM pins with programmable
// wait states and stalls the initiator until the matching access is done.
module ext_sram_ctrl
  import ext_mem_pkg::*;
#(
  parameter int ADDR_W    = 18,
  parameter int DATA_W    = 16,
  parameter int RD_CYCLES = SRAM_RD_CYCLES,
  parameter int WE_CYCLES = SRAM_WE_CYCLES
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] addr_i,
  inout  wire  [DATA_W-1:0] data_io,
  input  logic              re_i,
  input  logic              we_i,
  output logic              needWait_o,
  output logic [ADDR_W-1:0] sram_addr,
  inout  wire  [DATA_W-1:0] sram_dq,
  output logic              sram_ce_n,
  output logic              sram_oe_n,
  output logic              sram_we_n,
  output logic              sram_ub_n,
  output logic              sram_lb_n
);

  localparam int CNT_MAX = (RD_CYCLES > WE_CYCLES) ? RD_CYCLES : WE_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX) + 1;

  state_t              state_reg, state_next;
  logic [CNT_W-1:0]    cnt_reg, cnt_next;
  op_t                 op_reg;
  logic [ADDR_W-1:0]   addr_reg;
  logic [DATA_W-1:0]   wdata_reg;
  logic [DATA_W-1:0]   rdata_reg;
  logic                dq_drive;
  logic                match;
  logic                done_match;

  // State and wait-counter registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  // Request latching and read-data capture on the edge that leaves R_ACC
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      op_reg    <= OP_READ;
      addr_reg  <= '0;
      wdata_reg <= '0;
      rdata_reg <= '0;
    end else begin
      if (state_reg == IDLE) begin
        if (re_i) begin
          op_reg   <= OP_READ;
          addr_reg <= addr_i;
        end else if (we_i) begin
          op_reg    <= OP_WRITE;
          addr_reg  <= addr_i;
          wdata_reg <= data_io;
        end
      end
      if (state_reg == R_ACC && cnt_reg == '0) begin
        rdata_reg <= sram_dq;
      end
    end
  end

  // Next-state, counter and SRAM control decode; controls come straight from
  // the state so an asynchronous reset releases the pins immediately
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    sram_ce_n  = 1'b1;
    sram_oe_n  = 1'b1;
    sram_we_n  = 1'b1;
    sram_ub_n  = 1'b1;
    sram_lb_n  = 1'b1;
    dq_drive   = 1'b0;
    case (state_reg)
      IDLE: begin
        if (re_i) begin
          state_next = R_ACC;
          cnt_next   = CNT_W'(RD_CYCLES - 1);
        end else if (we_i) begin
          state_next = W_SETUP;
        end
      end
      R_ACC: begin
        sram_ce_n = 1'b0;
        sram_oe_n = 1'b0;
        sram_ub_n = 1'b0;
        sram_lb_n = 1'b0;
        if (cnt_reg == '0) begin
          state_next = DONE;
        end else begin
          cnt_next = cnt_reg - CNT_W'(1);
        end
      end
      W_SETUP: begin
        sram_ce_n  = 1'b0;
        sram_ub_n  = 1'b0;
        sram_lb_n  = 1'b0;
        dq_drive   = 1'b1;
        state_next = W_PULSE;
        cnt_next   = CNT_W'(WE_CYCLES - 1);
      end
      W_PULSE: begin
        sram_ce_n = 1'b0;
        sram_we_n = 1'b0;
        sram_ub_n = 1'b0;
        sram_lb_n = 1'b0;
        dq_drive  = 1'b1;
        if (cnt_reg == '0) begin
          state_next = W_HOLD;
        end else begin
          cnt_next = cnt_reg - CNT_W'(1);
        end
      end
      W_HOLD: begin
        sram_ce_n  = 1'b0;
        sram_ub_n  = 1'b0;
        sram_lb_n  = 1'b0;
        dq_drive   = 1'b1;
        state_next = DONE;
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // The request is only released if it is still the one that was served;
  // a changed address or request type restarts from IDLE
  assign match = (addr_i == addr_reg) &&
                 ((op_reg == OP_READ) ? re_i : (we_i && !re_i));
  assign done_match = (state_reg == DONE) && match;

  assign needWait_o = (re_i || we_i) && !done_match;
  assign sram_addr  = addr_reg;
  assign sram_dq    = dq_drive ? wdata_reg : {DATA_W{1'bz}};
  assign data_io    = (done_match && op_reg == OP_READ) ? rdata_reg
                                                        : {DATA_W{1'bz}};

endmodule

// File: tb/tb_ext_sram_ctrl.sv
// Directed bench for ext_sram_ctrl with a behavioural 256Kx16 async SRAM.
module tb_ext_sram_ctrl;

  logic        clk;
  logic        reset_n;
  logic [17:0] addr_i;
  logic        re_i;
  logic        we_i;
  logic        needWait_o;
  logic [17:0] sram_addr;
  logic        sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n;
  wire  [15:0] data_io;
  wire  [15:0] sram_dq;

  logic        tb_en;
  logic [15:0] tb_d;
  logic        probe_en;
  logic [15:0] mem [0:262143];

  int vectors;
  int miscompares;

  ext_sram_ctrl #(
    .ADDR_W(18), .DATA_W(16), .RD_CYCLES(2), .WE_CYCLES(2)
  ) dut (
    .clk(clk), .reset_n(reset_n), .addr_i(addr_i), .data_io(data_io),
    .re_i(re_i), .we_i(we_i), .needWait_o(needWait_o), .sram_addr(sram_addr),
    .sram_dq(sram_dq), .sram_ce_n(sram_ce_n), .sram_oe_n(sram_oe_n),
    .sram_we_n(sram_we_n), .sram_ub_n(sram_ub_n), .sram_lb_n(sram_lb_n)
  );

  // Initiator side of the data bus (zeros when idle so a DUT drive shows up)
  assign data_io = tb_en ? tb_d : 16'hzzzz;
  // Zero probe on the SRAM bus to expose an unexpected DUT drive
  assign sram_dq = probe_en ? 16'h0000 : 16'hzzzz;
  // SRAM read drive
  assign sram_dq = (!sram_ce_n && !sram_oe_n && sram_we_n) ? mem[sram_addr] : 16'hzzzz;

  // SRAM write while WE is low
  always @(posedge clk) begin
    if (!sram_ce_n && !sram_we_n) mem[sram_addr] <= sram_dq;
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Starting at posedge+1, count stalled cycles until needWait_o drops
  task automatic wait_done(output int nw, output int oe_c, output int we_c,
                           output int ce_c, output logic [15:0] q);
    nw = 0; oe_c = 0; we_c = 0; ce_c = 0; q = '0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!needWait_o) begin
        q = data_io;
        break;
      end
      nw++;
      if (!sram_oe_n) oe_c++;
      if (!sram_we_n) we_c++;
      if (!sram_ce_n) ce_c++;
      @(posedge clk); #1;
    end
  endtask

  task automatic release_req();
    @(posedge clk); #1;
    re_i = 1'b0; we_i = 1'b0; tb_en = 1'b1; tb_d = 16'h0000;
  endtask

  task automatic access(input bit rd, input logic [17:0] a, input logic [15:0] d,
                        output int nw, output int oe_c, output int we_c,
                        output int ce_c, output logic [15:0] q);
    addr_i = a; re_i = rd; we_i = !rd; tb_en = !rd; tb_d = d;
    wait_done(nw, oe_c, we_c, ce_c, q);
    release_req();
  endtask

  initial begin
    int nw, oe_c, we_c, ce_c;
    logic [15:0] q;
    vectors = 0; miscompares = 0;
    mem[18'h00010] = 16'h1234;
    mem[18'h00001] = 16'h1111;
    mem[18'h00002] = 16'h2222;
    reset_n = 1'b0; re_i = 1'b1; we_i = 1'b0; addr_i = 18'h00010;
    tb_en = 1'b1; tb_d = 16'h0000; probe_en = 1'b1;

    // Reset with a read request pending
    #12;
    chk("rst_needwait", 32'(needWait_o), 32'd1);
    chk("rst_ctrl", 32'({sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n}), 32'h1f);
    chk("rst_sram_dq_z", 32'(sram_dq), 32'h0);
    chk("rst_data_io_z", 32'(data_io), 32'h0);
    chk("rst_sram_addr", 32'(sram_addr), 32'h0);
    @(negedge clk);
    reset_n = 1'b1; re_i = 1'b0; probe_en = 1'b0;
    @(negedge clk);
    chk("idle_needwait", 32'(needWait_o), 32'd0);
    chk("idle_ctrl", 32'({sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n}), 32'h1f);
    @(posedge clk); #1;

    // Plain read
    access(1'b1, 18'h00010, 16'h0, nw, oe_c, we_c, ce_c, q);
    $display("read  addr=00010 wait=%0d oe=%0d data=%h", nw, oe_c, q);
    chk("rd_wait", 32'(nw), 32'd3);
    chk("rd_oe_cycles", 32'(oe_c), 32'd2);
    chk("rd_data", 32'(q), 32'h1234);

    // Write at the top of the window
    access(1'b0, 18'h3FFFF, 16'hA5C3, nw, oe_c, we_c, ce_c, q);
    $display("write addr=3ffff wait=%0d we=%0d ce=%0d oe=%0d", nw, we_c, ce_c, oe_c);
    chk("wr_wait", 32'(nw), 32'd5);
    chk("wr_we_cycles", 32'(we_c), 32'd2);
    chk("wr_ce_cycles", 32'(ce_c), 32'd4);
    chk("wr_oe_cycles", 32'(oe_c), 32'd0);

    // Read back
    access(1'b1, 18'h3FFFF, 16'h0, nw, oe_c, we_c, ce_c, q);
    $display("read  addr=3ffff wait=%0d data=%h", nw, q);
    chk("rb_wait", 32'(nw), 32'd3);
    chk("rb_data", 32'(q), 32'hA5C3);

    // Back-to-back reads, address changed in the DONE cycle
    addr_i = 18'h00001; re_i = 1'b1; we_i = 1'b0; tb_en = 1'b0;
    repeat (3) @(posedge clk);
    #1 addr_i = 18'h00002;
    @(negedge clk);
    chk("b2b_done1_stall", 32'(needWait_o), 32'd1);
    @(posedge clk); #1;
    wait_done(nw, oe_c, we_c, ce_c, q);
    release_req();
    $display("b2b   addr=00002 wait=%0d data=%h", nw, q);
    chk("b2b_wait2", 32'(nw), 32'd3);
    chk("b2b_data", 32'(q), 32'h2222);

    // Abandoned write, then a read arriving during the write pulse
    addr_i = 18'h00020; we_i = 1'b1; re_i = 1'b0; tb_en = 1'b1; tb_d = 16'hBEEF;
    @(posedge clk); #1;
    we_i = 1'b0;
    @(negedge clk);
    chk("abn_no_stall", 32'(needWait_o), 32'd0);
    chk("abn_ce_low", 32'(sram_ce_n), 32'd0);
    @(posedge clk); #1;
    addr_i = 18'h00010; re_i = 1'b1; tb_en = 1'b0;
    wait_done(nw, oe_c, we_c, ce_c, q);
    release_req();
    $display("abn   read addr=00010 wait=%0d we=%0d data=%h", nw, we_c, q);
    chk("abn_wait", 32'(nw), 32'd7);
    chk("abn_we_cycles", 32'(we_c), 32'd2);
    chk("abn_rd_data", 32'(q), 32'h1234);
    chk("abn_mem_written", 32'(mem[18'h00020]), 32'hBEEF);

    // Reset in the middle of a read
    addr_i = 18'h00010; re_i = 1'b1; tb_en = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    chk("mid_oe_low", 32'(sram_oe_n), 32'd0);
    #2 reset_n = 1'b0; tb_en = 1'b1; tb_d = 16'h0000;
    #1;
    chk("mid_rst_ctrl", 32'({sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n}), 32'h1f);
    chk("mid_rst_needwait", 32'(needWait_o), 32'd1);
    chk("mid_rst_data_io_z", 32'(data_io), 32'h0);
    @(negedge clk);
    reset_n = 1'b1; re_i = 1'b0;
    @(posedge clk); #1;
    access(1'b1, 18'h3FFFF, 16'h0, nw, oe_c, we_c, ce_c, q);
    $display("read  after reset addr=3ffff wait=%0d data=%h", nw, q);
    chk("post_rst_wait", 32'(nw), 32'd3);
    chk("post_rst_data", 32'(q), 32'hA5C3);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
